// File: rtl/p2_stim_sweep_pkg.sv
// Shared definitions for the p2 stimulus sweep: FSM encodings and the
// step-to-ABC lookup that walks all eight inputs one bit change at a time.
package p2_stim_sweep_pkg;

  typedef enum logic [1:0] {
    P2_IDLE = 2'd0,
    P2_RUN  = 2'd1,
    P2_DONE = 2'd2
  } p2_state_t;

  localparam int         P2_STEPS     = 8;
  localparam logic [2:0] P2_LAST_STEP = 3'd7;

  // Returns {A,B,C} for a step; successive steps differ in exactly one bit.
  function automatic logic [2:0] step_to_abc(input logic [2:0] step);
    logic [2:0] abc;
    case (step)
      3'd0:    abc = 3'b000;
      3'd1:    abc = 3'b010;
      3'd2:    abc = 3'b110;
      3'd3:    abc = 3'b100;
      3'd4:    abc = 3'b101;
      3'd5:    abc = 3'b111;
      3'd6:    abc = 3'b011;
      default: abc = 3'b001;
    endcase
    return abc;
  endfunction

endpackage

// File: rtl/p2_stim_sweep_dwell_counter.sv
// Dwell counter: counts hold cycles of one input vector and flags the last one.
// Held at zero by clr; wraps back to zero on the cycle it flags.
module p2_dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [7:0] WRAP_AT = 8'(DWELL - 1);

  logic [7:0] count_reg;
  logic [7:0] count_next;

  assign wrap = (count_reg == WRAP_AT);

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = 8'd0;
    end else if (en) begin
      count_next = wrap ? 8'd0 : count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/p2_stim_sweep.sv
// Clocked sweep of the p2 function: drives all eight ABC combinations in
// single-bit-change order, samples F at the end of each hold, reports a truth table.
module p2_stim_sweep
  import p2_stim_sweep_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] vec_idx,
  output logic [7:0] truth
);

  p2_state_t  state_reg, state_next;
  logic [2:0] step_reg, step_next;
  logic [7:0] truth_reg, truth_next;
  logic       wrap;
  logic       sample;
  logic       accept;
  logic [2:0] abc;

  p2_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_reg != P2_RUN),
    .en    (state_reg == P2_RUN),
    .wrap  (wrap)
  );

  assign sample = (state_reg == P2_RUN) && wrap;
  assign accept = (state_reg == P2_IDLE) && start;
  assign abc    = (state_reg == P2_RUN) ? step_to_abc(step_reg) : 3'b000;

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    case (state_reg)
      P2_IDLE: begin
        if (start) begin
          state_next = P2_RUN;
          step_next  = 3'd0;
        end
      end
      P2_RUN: begin
        if (sample) begin
          // Step returns to 0 after the last sample so vec_idx tracks ABC = 000.
          if (step_reg == P2_LAST_STEP) begin
            state_next = P2_DONE;
            step_next  = 3'd0;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end
      end
      P2_DONE: begin
        state_next = P2_IDLE;
      end
      default: begin
        state_next = P2_IDLE;
        step_next  = 3'd0;
      end
    endcase
  end

  // Each signature bit captures F only when its own ABC vector is on the bus.
  generate
    for (genvar gi = 0; gi < P2_STEPS; gi++) begin : g_truth
      assign truth_next[gi] = accept                         ? 1'b0 :
                              (sample && (abc == 3'(gi)))    ? f_in :
                                                               truth_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= P2_IDLE;
      step_reg  <= 3'd0;
      truth_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      truth_reg <= truth_next;
    end
  end

  assign a_out   = abc[2];
  assign b_out   = abc[1];
  assign c_out   = abc[0];
  assign busy    = (state_reg == P2_RUN);
  assign done    = (state_reg == P2_DONE);
  assign vec_idx = step_reg;
  assign truth   = truth_reg;

endmodule

// File: tb/tb_p2_stim_sweep.sv
// Bench for p2_stim_sweep: two instances (DWELL 4 and 2) driven by truth-table
// functions, checked cycle by cycle against a timing model derived from the step order.
module tb_p2_stim_sweep;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start_v = 2'b00;
  logic [1:0] f_v, a_v, b_v, c_v, busy_v, done_v;
  logic [2:0] vidx_v [2];
  logic [7:0] truth_v [2];
  logic [7:0] tt_v [2];

  int n_cmp = 0;
  int n_bad = 0;
  int dw [2] = '{4, 2};
  logic [2:0] step_abc [8] = '{3'd0, 3'd2, 3'd6, 3'd4, 3'd5, 3'd7, 3'd3, 3'd1};

  always #5 clk = ~clk;

  // The "function under test" for each instance is a lookup into a truth table.
  assign f_v[0] = tt_v[0][{a_v[0], b_v[0], c_v[0]}];
  assign f_v[1] = tt_v[1][{a_v[1], b_v[1], c_v[1]}];

  p2_stim_sweep #(.DWELL(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .f_in(f_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .c_out(c_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .vec_idx(vidx_v[0]), .truth(truth_v[0])
  );

  p2_stim_sweep #(.DWELL(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .f_in(f_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .c_out(c_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .vec_idx(vidx_v[1]), .truth(truth_v[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind: 0 A^B^C, 1 A&B, 2 C, 3 const 1, 4 ~A
  function automatic logic [7:0] build_tt(input int kind);
    logic [7:0] t;
    logic [2:0] v;
    t = 8'h00;
    for (int x = 0; x < 8; x++) begin
      v = 3'(x);
      case (kind)
        0:       t[x] = v[2] ^ v[1] ^ v[0];
        1:       t[x] = v[2] & v[1];
        2:       t[x] = v[0];
        3:       t[x] = 1'b1;
        default: t[x] = ~v[2];
      endcase
    end
    return t;
  endfunction

  task automatic check_quiet(input int w, input string tag, input logic [7:0] exp_truth);
    check($sformatf("%s busy w%0d", tag, w), 32'(busy_v[w]), 32'd0);
    check($sformatf("%s done w%0d", tag, w), 32'(done_v[w]), 32'd0);
    check($sformatf("%s abc w%0d", tag, w), 32'({a_v[w], b_v[w], c_v[w]}), 32'd0);
    check($sformatf("%s vidx w%0d", tag, w), 32'(vidx_v[w]), 32'd0);
    check($sformatf("%s truth w%0d", tag, w), 32'(truth_v[w]), 32'(exp_truth));
  endtask

  // Call at #1 after an edge with the instance idle. pulse_step >= 0 re-pulses
  // start at the first cycle of that step; hold keeps start high throughout.
  task automatic run_sweep(input int w, input logic [7:0] tt, input int pulse_step, input bit hold);
    int d;
    d = dw[w];
    tt_v[w] = tt;
    start_v[w] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_v[w] = 1'b0;
    for (int j = 1; j <= 8 * d; j++) begin
      int s;
      s = (j - 1) / d;
      check($sformatf("run busy w%0d c%0d", w, j), 32'(busy_v[w]), 32'd1);
      check($sformatf("run done w%0d c%0d", w, j), 32'(done_v[w]), 32'd0);
      check($sformatf("run abc w%0d c%0d", w, j), 32'({a_v[w], b_v[w], c_v[w]}), 32'(step_abc[s]));
      check($sformatf("run vidx w%0d c%0d", w, j), 32'(vidx_v[w]), 32'(s));
      if (j == 1) check($sformatf("run clr w%0d", w), 32'(truth_v[w]), 32'd0);
      if (s == pulse_step && ((j - 1) % d) == 0) start_v[w] = 1'b1;
      else if (!hold) start_v[w] = 1'b0;
      @(posedge clk); #1;
    end
    if (!hold) start_v[w] = 1'b0;
    check($sformatf("done pulse w%0d", w), 32'(done_v[w]), 32'd1);
    check($sformatf("done busy w%0d", w), 32'(busy_v[w]), 32'd0);
    check($sformatf("done abc w%0d", w), 32'({a_v[w], b_v[w], c_v[w]}), 32'd0);
    check($sformatf("done truth w%0d", w), 32'(truth_v[w]), 32'(tt));
    $display("sweep w%0d dwell=%0d tt=%02h truth=%02h", w, d, tt, truth_v[w]);
    @(posedge clk); #1;
    check_quiet(w, "post", tt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tt;
    tt_v[0] = 8'h00;
    tt_v[1] = 8'h00;

    // Reset then idle
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_quiet(0, "idle", 8'h00);
      check_quiet(1, "idle", 8'h00);
    end

    run_sweep(0, build_tt(0), -1, 1'b0);   // XOR, 8'h96
    check("xor sig", 32'(truth_v[0]), 32'h96);
    run_sweep(1, build_tt(1), -1, 1'b0);   // A&B, 8'hC0
    check("and sig", 32'(truth_v[1]), 32'hC0);
    run_sweep(0, build_tt(2), 3, 1'b0);    // ignored start at step 3, 8'hAA
    check("c sig", 32'(truth_v[0]), 32'hAA);
    @(posedge clk); #1;
    check_quiet(0, "no requeue", 8'hAA);

    // Reset mid-sweep at step 5
    tt_v[0] = 8'h5A;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (5 * 4) @(posedge clk);
    #1;
    check("mid step5 abc", 32'({a_v[0], b_v[0], c_v[0]}), 32'(step_abc[5]));
    #2 rst_n = 1'b0;
    #1;
    check_quiet(0, "async rst", 8'h00);
    @(posedge clk); #1;
    check_quiet(0, "in rst", 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check_quiet(0, "after rst", 8'h00);
    run_sweep(0, build_tt(3), -1, 1'b0);   // const 1, 8'hFF
    check("one sig", 32'(truth_v[0]), 32'hFF);

    // Back-to-back with start held high, ~A
    run_sweep(0, build_tt(4), -1, 1'b1);
    run_sweep(0, build_tt(4), -1, 1'b0);
    check("nota sig", 32'(truth_v[0]), 32'h0F);

    // Random functions on both instances
    for (int r = 0; r < 6; r++) begin
      tt = 8'($urandom);
      run_sweep(r % 2, tt, int'($urandom_range(0, 9)) - 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
